// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: word width, reset defaults,
// fetch FSM encoding and the IF/ID payload record.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } ifid_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching an instruction returned while decode stalls.
module fetch_skid
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  ifid_t din,
    output ifid_t dout,
    output logic  full
);

    ifid_t entry;

    // Clear wins over load so a redirect or flush can never leave a stale word behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry <= '0;
            full  <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            entry <= din;
            full  <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    assign dout = entry;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC sequencing, instruction-memory handshake,
// skid buffering across decode stalls and the IF/ID pipeline register.
module fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc4,
    output logic            if_valid
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic            xfer;
    logic            kill;
    logic            skid_load;
    logic            skid_unload;
    logic            skid_full;
    ifid_t           skid_din;
    ifid_t           skid_dout;

    assign xfer      = imem_req & imem_ready;
    assign pc_inc    = pc + PC_STEP;
    assign imem_addr = pc;

    // Redirect and flush both squash whatever would enter IF/ID this cycle,
    // including a parked skid entry: the pc has already moved past it.
    assign kill        = redirect | flush;
    assign skid_load   = !kill && stall && xfer;
    assign skid_unload = !kill && !stall && skid_full;
    assign skid_din    = '{instr: imem_rdata, pc4: pc_inc};

    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (kill),
        .din    (skid_din),
        .dout   (skid_dout),
        .full   (skid_full)
    );

    // FSM with imem_req registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
        end else begin
            if (redirect)
                pc <= word_align(redirect_pc);
            else if (xfer)
                pc <= pc_inc;

            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (skid_load) begin
                        state    <= S_HOLD;
                        imem_req <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (kill || !stall) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register; if_pc4 is left alone on bubbles since it is only
    // meaningful alongside if_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc4   <= '0;
        end else if (kill) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (skid_full) begin
                if_valid <= 1'b1;
                if_instr <= skid_dout.instr;
                if_pc4   <= skid_dout.pc4;
            end else if (xfer) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc4   <= pc_inc;
            end else begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch against a queue-based model, plus literal
// directed sequences and a wrapped-reset-PC instance.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ready = 1'b0;
    logic        imem_req, if_valid, imem_req2, if_valid2;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc4;
    logic [31:0] imem_addr2, imem_rdata2, if_instr2, if_pc42;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata  = word(imem_addr);
    assign imem_rdata2 = word(imem_addr2);

    fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_instr(if_instr),
        .if_pc4(if_pc4), .if_valid(if_valid)
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata2), .if_instr(if_instr2),
        .if_pc4(if_pc42), .if_valid(if_valid2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a started flag, a pc, a 0/1-deep queue of parked
    // instructions and the visible IF/ID slot.
    bit          m_started = 0;
    logic [31:0] m_pc = 32'h0;
    slot_t       m_skid[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc4 = 32'h0;

    function automatic bit m_req();
        return m_started && (m_skid.size() == 0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_started = 0;
            m_pc      = 32'h0;
            m_skid.delete();
            m_valid   = 1'b0;
            m_instr   = NOP;
            m_pc4     = 32'h0;
        end else begin
            bit    xfer;
            slot_t got;
            xfer = m_req() && imem_ready;
            got  = '{instr: word(m_pc), pc4: m_pc + 32'd4};
            if (redirect) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                m_skid.delete();
                m_valid = 1'b0;
                m_instr = NOP;
            end else begin
                if (xfer) m_pc = m_pc + 32'd4;
                if (flush) begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                    m_skid.delete();
                end else if (stall) begin
                    if (xfer) m_skid.push_back(got);
                end else if (m_skid.size() != 0) begin
                    slot_t s;
                    s = m_skid.pop_front();
                    m_valid = 1'b1; m_instr = s.instr; m_pc4 = s.pc4;
                end else if (xfer) begin
                    m_valid = 1'b1; m_instr = got.instr; m_pc4 = got.pc4;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end
            m_started = 1;
        end
    end

    always @(negedge clk) begin
        chk("m_req",   {31'b0, imem_req}, {31'b0, m_req()});
        chk("m_addr",  imem_addr, m_pc);
        chk("m_valid", {31'b0, if_valid}, {31'b0, m_valid});
        chk("m_instr", if_instr, m_instr);
        if (m_valid) chk("m_pc4", if_pc4, m_pc4);
    end

    initial begin
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc4", if_pc4, 32'h0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
        rst = 1'b1;

        // Streaming from reset
        @(negedge clk);
        chk("s0_req", {31'b0, imem_req}, 32'd1);
        chk("s0_addr", imem_addr, 32'h0);
        chk("s0_valid", {31'b0, if_valid}, 32'd0);
        chk("w0_addr", imem_addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("s1_addr", imem_addr, 32'h4);
        chk("s1_valid", {31'b0, if_valid}, 32'd1);
        chk("s1_pc4", if_pc4, 32'h4);
        chk("s1_instr", if_instr, word(32'h0));
        chk("w1_addr", imem_addr2, 32'h0);
        chk("w1_pc4", if_pc42, 32'h0);
        chk("w1_instr", if_instr2, word(32'hFFFF_FFFC));
        @(negedge clk);
        chk("s2_addr", imem_addr, 32'h8);
        chk("s2_pc4", if_pc4, 32'h8);

        // Memory not ready for three cycles at address 8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nr_addr", imem_addr, 32'h8);
            chk("nr_valid", {31'b0, if_valid}, 32'd0);
            chk("nr_instr", if_instr, NOP);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        chk("nr_done_addr", imem_addr, 32'hC);
        chk("nr_done_pc4", if_pc4, 32'hC);
        chk("nr_done_instr", if_instr, word(32'h8));

        // Two-cycle stall while streaming
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("st_req", {31'b0, imem_req}, 32'd0);
            chk("st_addr", imem_addr, 32'h10);
            chk("st_pc4", if_pc4, 32'hC);
            chk("st_valid", {31'b0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("st_rel_req", {31'b0, imem_req}, 32'd1);
        chk("st_rel_pc4", if_pc4, 32'h10);
        chk("st_rel_instr", if_instr, word(32'hC));
        @(negedge clk);
        chk("st_next_pc4", if_pc4, 32'h14);
        chk("st_next_addr", imem_addr, 32'h14);

        // Redirect with a transfer in flight
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_valid", {31'b0, if_valid}, 32'd0);
        redirect = 1'b0;
        @(negedge clk);
        chk("rd_pc4", if_pc4, 32'h104);
        chk("rd_instr", if_instr, word(32'h100));

        // Flush together with stall, then redirect+flush+stall
        flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        chk("fs_valid", {31'b0, if_valid}, 32'd0);
        chk("fs_instr", if_instr, NOP);
        chk("fs_addr", imem_addr, 32'h108);
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        @(negedge clk);
        chk("rfs_addr", imem_addr, 32'h200);
        chk("rfs_valid", {31'b0, if_valid}, 32'd0);
        redirect = 1'b0; flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("rfs_pc4", if_pc4, 32'h204);
        chk("rfs_instr", if_instr, word(32'h200));

        // Asynchronous reset in the middle of streaming
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_req", {31'b0, imem_req}, 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_valid", {31'b0, if_valid}, 32'd0);
        chk("ar_instr", if_instr, NOP);
        chk("ar_pc4", if_pc4, 32'h0);
        chk("ar_addr2", imem_addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            imem_ready  = ($urandom_range(0, 9) < 7);
            stall       = ($urandom_range(0, 9) < 2);
            flush       = ($urandom_range(0, 19) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        #1;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word driven on if_instr when if_valid=0.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low (asserted when 0).
REQ-005 stall  in  1  decode-stage hazard stall; IF/ID register shall hold.
REQ-006 flush  in  1  kill the instruction entering IF/ID this cycle.
REQ-007 redirect  in  1  taken branch/jump from decode/execute.
REQ-008 redirect_pc  in  32  target address for redirect.
REQ-009 imem_req  out  1  instruction-memory read request.
REQ-010 imem_addr  out  32  word-aligned fetch address.
REQ-011 imem_ready  in  1  memory accepts the request and returns data this cycle.
REQ-012 imem_rdata  in  32  instruction word, valid when imem_req & imem_ready.
REQ-013 if_instr  out  32  IF/ID instruction to decode.
REQ-014 if_pc4  out  32  IF/ID PC+4 of if_instr.
REQ-015 if_valid  out  1  IF/ID slot holds a real instruction.

Function
REQ-016 A transfer is a rising edge with imem_req=1 and imem_ready=1.
REQ-017 FSM states: IDLE (after reset), FETCH (request outstanding), HOLD (skid buffer full, no request).
REQ-018 IDLE -> FETCH on the first rising edge after reset release; imem_req=0 in IDLE.
REQ-019 In FETCH, imem_req=1 and imem_addr=pc; on transfer, pc <= pc+4 and the next request is issued the following cycle, giving one instruction per cycle when imem_ready is tied high.
REQ-020 Transfer with stall=0: if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1 on the same edge (one-cycle fetch latency).
REQ-021 No transfer and stall=0: if_valid<=0, if_instr<=NOP_INSTR (bubble).
REQ-022 stall=1: IF/ID holds; a transfer in that cycle loads the one-entry skid buffer and FSM goes FETCH -> HOLD.
REQ-023 HOLD: imem_req=0; on the first edge with stall=0 the skid entry moves to IF/ID, buffer empties, FSM -> FETCH.
REQ-024 redirect=1 (any state): pc<=redirect_pc with bits[1:0] forced to 2'b00, skid buffer cleared, if_valid<=0, FSM -> FETCH; the instruction returned by a transfer in that cycle is discarded.
REQ-025 Priority: redirect > flush > stall > normal update.
REQ-026 flush=1 without redirect: if_valid<=0 and if_instr<=NOP_INSTR even if stall=1; a transfer in that cycle is discarded and pc still advances.
REQ-027 imem_addr may change while imem_req=1 without imem_ready only on redirect (instruction memory is read-only; abort is safe); otherwise it shall be stable until transfer.
REQ-028 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000; if_pc4 wraps identically.

Reset
REQ-029 While rst=0: pc=RESET_PC, FSM=IDLE, skid empty, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc4=0, immediately and independent of clk.
REQ-030 Reset asserted mid-transfer aborts it; no partial IF/ID update survives.

Structure
REQ-031 Shared package mips_pkg holds the FSM state encoding, RESET_PC default, NOP_INSTR and the 32-bit word width constant.
REQ-032 The skid buffer shall be a sub-module fetch_skid (one entry: instr, pc4, full flag, load/unload/clear).

Verification
REQ-033 Reset release, imem_ready=1 tied: imem_addr 0,4,8,C on consecutive cycles; if_valid=1 from the 2nd edge, if_pc4 4,8,C.
REQ-034 imem_ready=0 for 3 cycles at addr 8: imem_addr stays 8, three bubbles (if_valid=0), then instr at 8 with if_pc4=C.
REQ-035 stall=1 for 2 cycles during streaming: IF/ID frozen, FSM enters HOLD, imem_req=0; after release the buffered instr appears once, none lost or duplicated.
REQ-036 redirect=1, redirect_pc=32'h0000_0103 during pending fetch: next imem_addr=32'h0000_0100, if_valid=0 one cycle, returned word of old address never reaches IF/ID.
REQ-037 flush and stall together: if_valid=0, if_instr=NOP_INSTR next edge; redirect+flush+stall together behaves as REQ-036.
REQ-038 RESET_PC=32'hFFFF_FFFC, ready=1: imem_addr FFFF_FFFC then 0000_0000; rst=0 asserted mid-stream clears all outputs asynchronously before the next edge.
